// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM encoding, NOP word.
package cpu_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned INST_W = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until all-ones and stick there.
  always_comb begin
    cnt_d = cnt_q;
    if (!clr_n) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, ROM address, instruction register with
// stall / redirect / halt control and a saturating fetch counter.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned INST_W = cpu_pkg::INST_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_code,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic              advance;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: boot lasts one cycle; halt is left only via redirect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN:  if (!redirect_valid && halt_req) state_d = S_HALT;
      S_HALT: if (redirect_valid) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM outputs / datapath next values; priority redirect > halt > stall > advance.
  always_comb begin
    pc_d       = pc_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    advance    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_addr;
          if_valid_d = 1'b0;
        end else if (halt_req) begin
          if_valid_d = 1'b0;
        end else if (!stall) begin
          advance    = 1'b1;
          if_inst_d  = inst_code;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
        end
      end
      S_HALT: begin
        if_valid_d = 1'b0;
        if (redirect_valid) pc_d = redirect_addr;
      end
      default: begin
        if_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= '0;
      if_inst_q  <= INST_W'(NOP);
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Counter clear is the block reset so it tracks the other state exactly.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_fetch_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .en   (advance),
    .cnt  (fetch_cnt)
  );

  assign inst_addr = pc_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;
  assign halted    = (state_q == S_HALT);

endmodule
